load_store_unit: RTL

- Data-memory access stage between the core's ALU/register-file outputs and the synchronous single-port data RAM.
- The RAM has 1-cycle registered read latency and word-only writes.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW: formats and sign-extends loads, and performs read-modify-write for sub-word stores.
- Asserts `stall` so the core holds PC while a multi-cycle access is in flight.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/lsu_format.sv | 58 +++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access sizes,
// RV32I funct3 encodings and the funct3 legality helper.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LD_WAIT,
        S_LD_RESP,
        S_RMW_MERGE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 inside {F3_B, F3_H, F3_W};
        end
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and RAM-side signals of the load/store unit.
// slave = the LSU itself, master = the core plus data RAM around it.
interface load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              fault;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wren;
    logic [31:0]       mem_q;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        output stall, rsp_valid, rsp_rdata, fault, mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        input  stall, rsp_valid, rsp_rdata, fault, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/lsu_format.sv
// Combinational data path of the LSU: load byte/half extraction with sign or
// zero extension, and byte-lane merge of store data into a read word.
module lsu_format
    import lsu_pkg::*;
(
    input  size_t       i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_mem_q,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_mem_q >> {i_offset, 3'b000};

    always_comb begin
        o_load_data = w_shifted;
        case (i_size)
            SZ_B:    o_load_data = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: o_load_data = w_shifted;
        endcase
    end

    // Each lane takes either the old RAM byte or the matching byte of the
    // store data, which always comes from the low bits of rs2.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic              w_lane_en;
        logic [BYTE_W-1:0] w_lane_src;

        always_comb begin
            w_lane_en  = 1'b1;
            w_lane_src = i_wdata[BYTE_W*gi +: BYTE_W];
            case (i_size)
                SZ_B: begin
                    w_lane_en  = (i_offset == LANE);
                    w_lane_src = i_wdata[BYTE_W-1:0];
                end
                SZ_H: begin
                    w_lane_en  = (i_offset[1] == LANE[1]);
                    w_lane_src = i_wdata[BYTE_W*(gi%2) +: BYTE_W];
                end
                default: begin
                    w_lane_en  = 1'b1;
                    w_lane_src = i_wdata[BYTE_W*gi +: BYTE_W];
                end
            endcase
        end

        assign o_merge_data[BYTE_W*gi +: BYTE_W] =
            w_lane_en ? w_lane_src : i_mem_q[BYTE_W*gi +: BYTE_W];
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a 1-cycle-latency word RAM.
// Define LSU_MISALIGN_CHK_EN to enable misalignment/illegal-funct3 faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_addr, w_req_word;
    size_t             r_size, w_size;
    logic              r_unsigned, w_unsigned;
    logic [1:0]        r_off, w_off;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [31:0]       w_load_data, w_merge_data;
    logic              w_legal, w_bad;
    logic              w_unused;

    // Address bits above the RAM depth alias, so they are deliberately dropped.
    assign w_req_word = bus.req_addr[ADDR_W+1:2];
    assign w_unused   = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        w_legal    = f3_legal(bus.req_we, bus.req_funct3);
        w_unsigned = w_legal & bus.req_funct3[2];
        w_size     = SZ_W;
        if (w_legal) begin
            case (bus.req_funct3[1:0])
                2'd0:    w_size = SZ_B;
                2'd1:    w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end
`ifdef LSU_MISALIGN_CHK_EN
        w_bad = !w_legal
              || (w_size == SZ_H && bus.req_addr[0])
              || (w_size == SZ_W && bus.req_addr[1:0] != 2'b00);
        w_off = bus.req_addr[1:0];
`else
        // Without checking, offset bits below the access size are ignored.
        w_bad = 1'b0;
        case (w_size)
            SZ_B:    w_off = bus.req_addr[1:0];
            SZ_H:    w_off = {bus.req_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
`endif
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_size     <= SZ_W;
            r_unsigned <= 1'b0;
            r_off      <= 2'b00;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && bus.req_valid) begin
                r_addr     <= w_req_word;
                r_size     <= w_size;
                r_unsigned <= w_unsigned;
                r_off      <= w_off;
                r_wdata    <= bus.req_wdata;
            end
            if (r_state == S_LD_WAIT) begin
                r_rdata <= w_load_data;
            end
        end
    end

    lsu_format u_format (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_offset     (r_off),
        .i_mem_q      (bus.mem_q),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    assign bus.rsp_rdata = r_rdata;

    always_comb begin
        w_next_state  = r_state;
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.fault     = 1'b0;
        bus.mem_wren  = 1'b0;
        bus.mem_wdata = '0;
        bus.mem_addr  = r_addr;
        case (r_state)
            S_IDLE: begin
                bus.mem_addr = w_req_word;
                if (bus.req_valid) begin
                    if (w_bad) begin
                        bus.fault = 1'b1;
                    end else if (bus.req_we && w_size == SZ_W) begin
                        bus.mem_wren  = 1'b1;
                        bus.mem_wdata = bus.req_wdata;
                    end else if (bus.req_we) begin
                        bus.stall    = 1'b1;
                        w_next_state = S_RMW_MERGE;
                    end else begin
                        bus.stall    = 1'b1;
                        w_next_state = S_LD_WAIT;
                    end
                end
            end
            S_LD_WAIT: begin
                bus.stall    = 1'b1;
                w_next_state = S_LD_RESP;
            end
            S_LD_RESP: begin
                bus.rsp_valid = 1'b1;
                w_next_state  = S_IDLE;
            end
            S_RMW_MERGE: begin
                bus.mem_wren  = 1'b1;
                bus.mem_wdata = w_merge_data;
                w_next_state  = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        // Reset drops any pending merge write and holds the RAM port quiet.
        if (reset) begin
            bus.stall     = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.fault     = 1'b0;
            bus.mem_wren  = 1'b0;
            bus.mem_wdata = '0;
            bus.mem_addr  = '0;
            w_next_state  = S_IDLE;
        end
    end

endmodule
